// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (I) and a load-store requester (D). One transaction is in
// flight at a time; D has priority unless I has been starved for
// STARVE_LIMIT consecutive D grants. A flush squashes in-flight reads
// (the port is drained without a response) but never a committed store.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  // instruction-fetch side
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  // load-store side
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_mbe,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  // shared memory port
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [3:0]    mem_mbe_q, mem_mbe_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic d_req;
  logic i_starved;

  assign d_req     = d_read | d_write;
  assign i_starved = i_read && (starve_q == LIMIT);

  // Next-state, starvation counter, port command and response decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_mbe_d   = mem_mbe_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;

    unique case (state_q)
      IDLE: begin
        // I not waiting: its starvation history is irrelevant.
        if (!i_read) starve_d = '0;
        if (flush) begin
          // No grant during a flush cycle.
        end else if (d_req && !i_starved) begin
          state_d     = SERVE_D;
          // Read and write together is a store.
          mem_read_d  = ~d_write;
          mem_write_d = d_write;
          mem_addr_d  = d_addr;
          mem_mbe_d   = d_write ? d_mbe : 4'b1111;
          mem_wdata_d = d_write ? d_wdata : 32'd0;
          if (i_read && (starve_q != LIMIT)) starve_d = starve_q + CW'(1);
        end else if (i_read) begin
          state_d     = SERVE_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          mem_mbe_d   = 4'b1111;
          mem_wdata_d = 32'd0;
          starve_d    = '0;
        end
      end

      SERVE_I: begin
        if (mem_resp) begin
          // A flush landing with the response squashes it outright.
          i_resp      = ~flush;
          i_rdata     = flush ? 32'd0 : mem_rdata;
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      SERVE_D: begin
        if (mem_resp) begin
          // Stores are committed and always acknowledged; loads are
          // squashed by a coincident flush.
          d_resp      = mem_write_q | ~flush;
          d_rdata     = (mem_write_q | ~flush) ? mem_rdata : 32'd0;
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else if (flush && mem_read_q) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Command stays on the port until memory finishes; no response.
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // A flush clears starvation history in every state.
    if (flush) starve_d = '0;
  end

  // State and registered port command, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_mbe_q   <= 4'b1111;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_mbe_q   <= mem_mbe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_mbe   = mem_mbe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
